// File: rtl/ecu_pkg.sv
// Shared ECU definitions: sequencer state encoding, pc_end bit positions and
// default widths for the instruction stream and microcode step index.
package ecu_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned STEP_W_DEF = 3;
  localparam int unsigned LEN_W      = 2;

  // Bit positions inside the decoder's pc_end bus
  localparam int unsigned PC_LRC = 1;
  localparam int unsigned PC_INI = 0;

  typedef enum logic [2:0] {
    FETCH_OP = 3'd0,
    DECODE   = 3'd1,
    FETCH_D  = 3'd2,
    EXEC     = 3'd3,
    HALT     = 3'd4,
    FAULT    = 3'd5
  } state_e;

endpackage

// File: rtl/ecu_step_seq_step_ctr.sv
// Small up-counter with synchronous clear and enable; tc_c flags that the
// count equals the supplied terminal value.
module step_ctr #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] q,
  output logic         tc_c
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + W'(1);
    end
  end

  assign tc_c = (q == last);

endmodule

// File: rtl/ecu_step_seq.sv
// Fetch/execute sequencer for the ECU: fetches opcode plus 0-3 operand bytes,
// holds them for the decoder, and walks the microcode step index during EXEC.
module ecu_step_seq
  import ecu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_valid,
  output logic              mem_req,
  input  logic [LEN_W-1:0]  len,
  input  logic [1:0]        pc_end,
  input  logic              halt,
  output logic [DATA_W-1:0] insn,
  output logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] d2,
  output logic [DATA_W-1:0] d3,
  output logic [STEP_W-1:0] is,
  output logic              pc_inc,
  output logic              halted,
  output logic              fault
);

  state_e            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  op_idx;
  logic              op_tc_c;
  logic              is_tc_c;
  logic              end_c;
  logic              is_clr_c;
  logic              is_en_c;
  logic              op_clr_c;
  logic              op_en_c;

  assign end_c   = pc_end[PC_LRC] | pc_end[PC_INI];
  assign mem_req = !rst && ((state == FETCH_OP) || (state == FETCH_D));

  // Step index only survives while EXEC keeps running; everything else zeroes it
  assign is_en_c  = (state == EXEC);
  assign is_clr_c = !((state == EXEC) && !end_c && !is_tc_c);

  step_ctr #(.W(STEP_W)) u_is_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (is_clr_c),
    .en   (is_en_c),
    .last ({STEP_W{1'b1}}),
    .q    (is),
    .tc_c (is_tc_c)
  );

  // Operand slot index; terminal when the latched operand count is reached
  assign op_clr_c = (state == DECODE);
  assign op_en_c  = (state == FETCH_D) && mem_valid;

  step_ctr #(.W(LEN_W)) u_op_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (op_clr_c),
    .en   (op_en_c),
    .last (LEN_W'(len_q - LEN_W'(1))),
    .q    (op_idx),
    .tc_c (op_tc_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH_OP;
      insn   <= '0;
      d1     <= '0;
      d2     <= '0;
      d3     <= '0;
      len_q  <= '0;
      pc_inc <= 1'b0;
      halted <= 1'b0;
      fault  <= 1'b0;
    end else begin
      pc_inc <= 1'b0;
      case (state)
        FETCH_OP: begin
          if (mem_valid) begin
            insn   <= mem_data;
            d1     <= '0;
            d2     <= '0;
            d3     <= '0;
            pc_inc <= 1'b1;
            state  <= DECODE;
          end
        end
        DECODE: begin
          len_q <= len;
          state <= (len != '0) ? FETCH_D : EXEC;
        end
        FETCH_D: begin
          if (mem_valid) begin
            pc_inc <= 1'b1;
            case (op_idx)
              2'd0:    d1 <= mem_data;
              2'd1:    d2 <= mem_data;
              default: d3 <= mem_data;
            endcase
            if (op_tc_c) state <= EXEC;
          end
        end
        EXEC: begin
          if (end_c) begin
            if (halt) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state <= FETCH_OP;
            end
          end else if (is_tc_c) begin
            state <= FAULT;
            fault <= 1'b1;
          end
        end
        HALT: begin
          if (!halt) begin
            state  <= FETCH_OP;
            halted <= 1'b0;
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: state <= FETCH_OP;
      endcase
    end
  end

endmodule
